// File: rtl/bc_msg_arbiter.sv
// Broadcast message arbiter: one-entry holding slot per core, round-robin pick, registered single-cycle broadcast.
// Optional broadcast counter enabled by defining BC_MSG_COUNT_EN.
module bc_msg_arbiter #(
  parameter int CORE_COUNT    = 16,
  parameter int CORE_ID_WIDTH = 4,
  parameter int MSG_WIDTH     = 47
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORE_COUNT-1:0]           core_reset,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_bc_msg,
  input  logic [CORE_COUNT-1:0]           core_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           core_bc_msg_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg,
  output logic                            bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
  output logic [31:0]                     bc_msg_count
);

  logic [CORE_COUNT-1:0]    full;
  logic [CORE_COUNT-1:0]    req;
  logic [CORE_COUNT-1:0]    grant;
  logic [CORE_COUNT-1:0]    accept;
  logic [MSG_WIDTH-1:0]     data [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] ptr;
  logic [CORE_ID_WIDTH-1:0] grant_idx;
  logic                     grant_any;

  assign req = full & ~core_reset;

  // Round-robin: first requesting slot at or after ptr, wrapping past CORE_COUNT-1.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the search so no latch is inferred.
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < CORE_COUNT; off++) begin
      idx = int'(ptr) + off;
      if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CORE_ID_WIDTH'(idx);
      end
    end
  end

  // A slot being granted can take a new message in the same cycle.
  assign core_bc_msg_ready = ~core_reset & (~full | grant);
  assign accept            = core_bc_msg_valid & core_bc_msg_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (core_reset[i])  full[i] <= 1'b0;
        else if (accept[i]) full[i] <= 1'b1;
        else if (grant[i])  full[i] <= 1'b0;
      end
    end
  end

  // NOTE: slot payloads are not reset; they are only read while the matching full bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (accept[i]) data[i] <= core_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      bc_msg       <= '0;
      bc_msg_src   <= '0;
      bc_msg_valid <= 1'b0;
    end else begin
      bc_msg_valid <= grant_any;
      if (grant_any) begin
        bc_msg     <= data[grant_idx];
        bc_msg_src <= grant_idx;
        ptr        <= (grant_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef BC_MSG_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_q + 32'(bc_msg_valid);
  end

  assign bc_msg_count = count_q;
`else
  assign bc_msg_count = '0;
`endif

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Randomized and directed bench for bc_msg_arbiter against a cycle-level behavioural model.
module tb_bc_msg_arbiter;
  localparam int N = 16;
  localparam int W = 47;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   core_reset;
  logic [N*W-1:0] core_bc_msg;
  logic [N-1:0]   core_bc_msg_valid;
  logic [N-1:0]   core_bc_msg_ready;
  logic [W-1:0]   bc_msg;
  logic           bc_msg_valid;
  logic [3:0]     bc_msg_src;
  logic [31:0]    bc_msg_count;
  logic [W-1:0]   msg_arr [N];

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_full [N];
  logic [W-1:0] m_data [N];
  int          m_ptr;
  bit          m_v;
  logic [W-1:0] m_msg;
  int          m_src;
  int unsigned m_cnt;

  bc_msg_arbiter dut (
    .clk(clk), .rst(rst), .core_reset(core_reset), .core_bc_msg(core_bc_msg),
    .core_bc_msg_valid(core_bc_msg_valid), .core_bc_msg_ready(core_bc_msg_ready),
    .bc_msg(bc_msg), .bc_msg_valid(bc_msg_valid), .bc_msg_src(bc_msg_src),
    .bc_msg_count(bc_msg_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    core_bc_msg = '0;
    for (int i = 0; i < N; i++) core_bc_msg[i*W +: W] = msg_arr[i];
  end

  function automatic logic [31:0] exp_count();
`ifdef BC_MSG_COUNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    m_ptr = 0; m_v = 1'b0; m_msg = '0; m_src = 0; m_cnt = 0;
  endtask

  task automatic set_idle();
    core_bc_msg_valid = '0;
    core_reset = '0;
    for (int i = 0; i < N; i++) msg_arr[i] = '0;
  endtask

  // Called at posedge+1 with inputs set; checks ready, advances one clock, checks outputs.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    g = -1;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (g < 0 && m_full[k] && !core_reset[k]) g = k;
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !core_reset[i] && (!m_full[i] || g == i);
    @(negedge clk);
    vectors++;
    if (core_bc_msg_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL ready: got %h expected %h at %0t", core_bc_msg_ready, exp_ready, $time);
    end
    if (m_v) m_cnt++;
    if (g >= 0) begin
      m_v = 1'b1; m_msg = m_data[g]; m_src = g; m_ptr = (g + 1) % N;
    end else begin
      m_v = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (core_reset[i]) m_full[i] = 1'b0;
      else if (core_bc_msg_valid[i] && exp_ready[i]) begin
        m_full[i] = 1'b1; m_data[i] = msg_arr[i];
      end else if (g == i) m_full[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bc_msg_valid !== m_v) begin
      miscompares++;
      $display("FAIL bc_msg_valid: got %b expected %b at %0t", bc_msg_valid, m_v, $time);
    end
    vectors++;
    if (bc_msg !== m_msg) begin
      miscompares++;
      $display("FAIL bc_msg: got %h expected %h at %0t", bc_msg, m_msg, $time);
    end
    vectors++;
    if (bc_msg_src !== 4'(m_src)) begin
      miscompares++;
      $display("FAIL bc_msg_src: got %0d expected %0d at %0t", bc_msg_src, m_src, $time);
    end
    vectors++;
    if (bc_msg_count !== exp_count()) begin
      miscompares++;
      $display("FAIL bc_msg_count: got %0d expected %0d at %0t", bc_msg_count, exp_count(), $time);
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({bc_msg_valid, bc_msg, bc_msg_src, bc_msg_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b msg=%h src=%0d cnt=%0d expected zeros",
               bc_msg_valid, bc_msg, bc_msg_src, bc_msg_count);
    end
    core_reset = 16'h00F0;
    #1;
    vectors++;
    if (core_bc_msg_ready !== 16'hFF0F) begin
      miscompares++;
      $display("FAIL reset_ready: got %h expected ff0f", core_bc_msg_ready);
    end
    core_reset = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    core_bc_msg_valid[3] = 1'b1;
    msg_arr[3] = 47'h1234;
    cycle();
    set_idle();
    vectors++;
    if (core_bc_msg_ready[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", core_bc_msg_ready[3]);
    end
    cycle();
    vectors++;
    if (bc_msg_valid !== 1'b1 || bc_msg !== 47'h1234 || bc_msg_src !== 4'd3) begin
      miscompares++;
      $display("FAIL single_bcast: got v=%b msg=%h src=%0d expected v=1 msg=1234 src=3",
               bc_msg_valid, bc_msg, bc_msg_src);
    end
    cycle();
  endtask

  task automatic test_contention();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      int seen [$];
      core_bc_msg_valid = '1;
      for (int i = 0; i < N; i++) msg_arr[i] = W'(100 * round + i);
      cycle();
      set_idle();
      for (int c = 0; c < N + 1; c++) begin
        cycle();
        if (bc_msg_valid === 1'b1) seen.push_back(int'(bc_msg_src));
      end
      vectors++;
      if (seen.size() != N) begin
        miscompares++;
        $display("FAIL contention_count: got %0d strobes expected %0d", seen.size(), N);
      end
      for (int i = 0; i < seen.size() && i < N; i++) begin
        vectors++;
        if (seen[i] != i) begin
          miscompares++;
          $display("FAIL contention_order: round %0d slot %0d got src %0d expected %0d",
                   round, i, seen[i], i);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int got [$];
    do_reset();
    for (int m = 0; m < 8; m++) begin
      core_bc_msg_valid[5] = 1'b1;
      msg_arr[5] = W'(m);
      #1;
      vectors++;
      if (core_bc_msg_ready[5] !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready: msg %0d got ready %b expected 1", m, core_bc_msg_ready[5]);
      end
      cycle();
      if (bc_msg_valid === 1'b1) got.push_back(int'(bc_msg));
    end
    set_idle();
    for (int c = 0; c < 2; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1) got.push_back(int'(bc_msg));
    end
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL stream_count: got %0d strobes expected 8", got.size());
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      vectors++;
      if (got[i] != i) begin
        miscompares++;
        $display("FAIL stream_data: strobe %0d got %0d expected %0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_fairness();
    int seen [$];
    do_reset();
    core_bc_msg_valid[15] = 1'b1;
    msg_arr[15] = 47'h15;
    cycle();
    set_idle();
    cycle();
    core_bc_msg_valid[0]  = 1'b1;
    core_bc_msg_valid[14] = 1'b1;
    msg_arr[0]  = 47'h0A;
    msg_arr[14] = 47'h0E;
    cycle();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1) seen.push_back(int'(bc_msg_src));
    end
    vectors++;
    if (seen.size() != 2 || seen[0] != 0 || seen[1] != 14) begin
      miscompares++;
      $display("FAIL fairness_order: got %0d strobes first=%0d expected 0 then 14",
               seen.size(), (seen.size() > 0) ? seen[0] : -1);
    end
  endtask

  task automatic test_flush();
    int from7 = 0;
    int from2 = 0;
    do_reset();
    core_bc_msg_valid[2] = 1'b1;
    core_bc_msg_valid[7] = 1'b1;
    msg_arr[2] = 47'h222;
    msg_arr[7] = 47'h777;
    cycle();
    set_idle();
    core_reset[7] = 1'b1;
    core_bc_msg_valid[7] = 1'b1;
    msg_arr[7] = 47'h7777;
    #1;
    vectors++;
    if (core_bc_msg_ready[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b expected 0", core_bc_msg_ready[7]);
    end
    cycle();
    if (bc_msg_valid === 1'b1 && bc_msg_src === 4'd2) from2++;
    set_idle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1 && bc_msg_src === 4'd7) from7++;
      if (bc_msg_valid === 1'b1 && bc_msg_src === 4'd2) from2++;
    end
    vectors++;
    if (from7 != 0 || from2 != 1) begin
      miscompares++;
      $display("FAIL flush_bcast: got src7=%0d src2=%0d expected src7=0 src2=1", from7, from2);
    end
  endtask

  task automatic test_reset_counter();
    int strobes = 0;
    do_reset();
    vectors++;
    if (bc_msg_count !== 32'd0) begin
      miscompares++;
      $display("FAIL count_after_reset: got %0d expected 0", bc_msg_count);
    end
    core_bc_msg_valid = '1;
    cycle();
    set_idle();
    for (int c = 0; c < 17; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1) strobes++;
    end
    core_bc_msg_valid = 16'h000F;
    cycle();
    set_idle();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1) strobes++;
    end
    vectors++;
`ifdef BC_MSG_COUNT_EN
    if (strobes != 20 || bc_msg_count !== 32'd20) begin
`else
    if (strobes != 20 || bc_msg_count !== 32'd0) begin
`endif
      miscompares++;
      $display("FAIL count_20: got strobes=%0d count=%0d expected 20 strobes", strobes, bc_msg_count);
    end
    // Fill four slots, then hit rst between edges.
    core_bc_msg_valid = 16'h0F00;
    cycle();
    set_idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({bc_msg_valid, bc_msg, bc_msg_src, bc_msg_count} !== '0 || core_bc_msg_ready !== '1) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b msg=%h src=%0d cnt=%0d ready=%h expected zeros, ready ffff",
               bc_msg_valid, bc_msg, bc_msg_src, bc_msg_count, core_bc_msg_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bc_msg_valid === 1'b1) strobes++;
    end
    vectors++;
    if (strobes != 0) begin
      miscompares++;
      $display("FAIL post_reset_strobes: got %0d expected 0", strobes);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      core_bc_msg_valid = N'($urandom);
      core_reset = '0;
      if ($urandom_range(0, 5) == 0) core_reset[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) msg_arr[i] = W'({$urandom, $urandom});
      cycle();
    end
    set_idle();
    for (int c = 0; c < N + 2; c++) cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_fairness();
    test_flush();
    test_reset_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
